// File: rtl/ps2_pkg.sv
// PS/2 host transmitter shared definitions: FSM state encoding,
// keyboard command/response bytes and the frame parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        XFER,
        ACK,
        WAIT_IDLE,
        DONE,
        ERROR
    } state_t;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ECHO    = 8'hEE;
    localparam logic [7:0] RSP_ACK     = 8'hFA;

    // Odd parity over the data byte: total ones in {parity, data} is odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 line conditioning: 2-flop synchronizers on clock and data, optional
// clock glitch filter (PS2_TX_GLITCH_FILTER_EN), falling-edge pulse.
// Ports: clk, reset, ps2_clk_in, ps2_data_in -> clk_s, data_s, fe.
module ps2_line_sync #(
    parameter int FILTER_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic clk_s,
    output logic data_s,
    output logic fe
);
    import ps2_pkg::*;

    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_prev;
    logic       clk_f;

    // Idle bus is high, so the flops reset high to avoid a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            clk_prev  <= clk_f;
        end
    end

`ifdef PS2_TX_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_CYCLES - 1);

    logic [FW-1:0] flt_cnt;
    logic          clk_filt;

    // Follow the synchronized clock only after it has disagreed with the
    // filtered value for FILTER_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_filt <= 1'b1;
            flt_cnt  <= '0;
        end else if (clk_sync[1] == clk_filt) begin
            flt_cnt <= '0;
        end else if (flt_cnt == FLT_LAST) begin
            clk_filt <= clk_sync[1];
            flt_cnt  <= '0;
        end else begin
            flt_cnt <= flt_cnt + 1'b1;
        end
    end

    assign clk_f = clk_filt;
`else
    logic [31:0] unused_filter;
    assign unused_filter = FILTER_CYCLES;
    assign clk_f = clk_sync[1];
`endif

    assign clk_s  = clk_f;
    assign data_s = data_sync[1];
    assign fe     = clk_prev & ~clk_f;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, RTS, 8 data + parity +
// stop, ACK check, timeout). Optional clock glitch filter: PS2_TX_GLITCH_FILTER_EN.
// Ports: clk, reset, ps2_clk_in/ps2_data_in (line sense), ps2_clk_oe/ps2_data_oe
// (1 = pull low), tx_data/tx_valid/tx_ready (request), busy, tx_done, tx_error.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);
    import ps2_pkg::*;

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [8:0]    shift;
    logic [3:0]    bit_cnt;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] tmo_cnt;

    logic clk_s;
    logic data_s;
    logic fe;
    logic timed;

    ps2_line_sync #(
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_sync (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .clk_s      (clk_s),
        .data_s     (data_s),
        .fe         (fe)
    );

    // Timeout window covers everything from RTS until the bus returns idle.
    assign timed = (state == RTS) || (state == XFER) ||
                   (state == ACK) || (state == WAIT_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shift       <= '0;
            bit_cnt     <= '0;
            inh_cnt     <= '0;
            tmo_cnt     <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (tx_valid) begin
                        shift      <= {odd_parity(tx_data), tx_data};
                        bit_cnt    <= '0;
                        inh_cnt    <= '0;
                        tmo_cnt    <= '0;
                        ps2_clk_oe <= 1'b1;
                        tx_ready   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        ps2_data_oe <= 1'b1;
                        state       <= RTS;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end
                RTS: begin
                    // Start bit stays on data; hand the clock to the device.
                    ps2_clk_oe <= 1'b0;
                    bit_cnt    <= '0;
                    state      <= XFER;
                end
                XFER: begin
                    if (fe) begin
                        if (bit_cnt == 4'd9) begin
                            ps2_data_oe <= 1'b0;
                            state       <= ACK;
                        end else begin
                            ps2_data_oe <= ~shift[bit_cnt];
                        end
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ACK: begin
                    if (fe) begin
                        if (!data_s) begin
                            state <= WAIT_IDLE;
                        end else begin
                            tx_error <= 1'b1;
                            state    <= ERROR;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (clk_s && data_s) begin
                        tx_done <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE, ERROR: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    tx_ready    <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Later assignments win: timeout overrides any edge this cycle.
            if (timed) begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (tmo_cnt == TMO_LAST) begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    tx_done     <= 1'b0;
                    tx_error    <= 1'b1;
                    state       <= ERROR;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a behavioural PS/2 device model.
// Define PS2_TX_GLITCH_FILTER_EN to also exercise the clock glitch filter.
module tb_ps2_host_tx;

    localparam int INH = 40;
    localparam int TMO = 2000;
    localparam int FLT = 4;

    localparam int K_DONE  = 0;
    localparam int K_NOACK = 1;
    localparam int K_TMO   = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk_oe, ps2_data_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_error;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_line, ps2_data_line;

    // Open-drain wired-AND bus
    assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_line = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_CYCLES (FLT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk_in (ps2_clk_line),
        .ps2_data_in(ps2_data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        logic [9:0] bits;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int         dev_mode = K_TMO;
    int         dev_h = 15;
    bit         dev_glitch = 1'b0;
    int         dev_falls = 0;
    logic [9:0] dev_bits = '0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame: data LSB first, odd parity, stop bit (released = 1)
    function automatic logic [9:0] ref_bits(input logic [7:0] d);
        logic [9:0] b;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            b[i] = (d >> i) & 1;
            ones += int'((d >> i) & 1);
        end
        b[8] = (ones % 2 == 0);
        b[9] = 1'b1;
        return b;
    endfunction

    // ---------------- device model ----------------
    task automatic dwait(input int n, inout bit ab);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (!busy) ab = 1'b1;
        end
    endtask

    task automatic dev_run();
        bit ab;
        ab = 1'b0;
        for (int i = 0; i < 10; i++) begin
            dwait(dev_h, ab);
            if (ab) break;
            dev_clk = 1'b0;
            dev_falls++;
            dwait(dev_h, ab);
            if (ab) break;
            dev_clk = 1'b1;
            dev_bits[i] = ps2_data_line;
            if (dev_glitch && i == 3) begin
                dwait(dev_h / 2, ab);
                dev_clk = 1'b0;
                dwait(2, ab);
                dev_clk = 1'b1;
            end
        end
        if (!ab) begin
            dwait(dev_h / 2, ab);
            dev_data = (dev_mode == K_NOACK);
            dwait(dev_h - dev_h / 2, ab);
            dev_clk = 1'b0;
            dev_falls++;
            dwait(dev_h, ab);
        end
        dev_clk  = 1'b1;
        dev_data = 1'b1;
    endtask

    initial begin : device
        forever begin
            @(negedge clk);
            if (!reset && !ps2_clk_oe && ps2_data_oe && dev_mode != K_TMO)
                dev_run();
        end
    end

    // ---------------- monitor ----------------
    int inh_run = 0;
    int rts_t = 0;
    bit rts_on = 1'b0;
    bit err_follow = 1'b0;

    always @(negedge clk) begin
        if (err_follow) begin
            chk("ready_after_error", tx_ready, 1);
            err_follow = 1'b0;
        end
        if (rts_on) rts_t++;
        if (ps2_clk_oe && !ps2_data_oe) begin
            inh_run++;
        end else if (ps2_clk_oe && ps2_data_oe) begin
            chk("inhibit_len", inh_run, INH);
            inh_run = 0;
            rts_t = 0;
            rts_on = 1'b1;
        end else begin
            inh_run = 0;
        end
        if (!reset && (tx_done || tx_error)) begin
            if (sbq.size() == 0) begin
                chk("unexpected_pulse", {tx_done, tx_error}, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("tx_done", tx_done, e.kind == K_DONE);
                chk("tx_error", tx_error, e.kind != K_DONE);
                if (e.kind != K_TMO) chk("frame_bits", dev_bits, e.bits);
                if (e.kind == K_TMO) chk("timeout_latency", rts_t, TMO);
                if (tx_error) begin
                    chk("lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
                    err_follow = 1'b1;
                end
                rts_on = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < INH + TMO + 500) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_wait_expired", busy, 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic start(input logic [7:0] d, input int mode, input int h, input bit gl);
        exp_t e;
        dev_mode = mode;
        dev_h = h;
        dev_glitch = gl;
        dev_falls = 0;
        @(negedge clk);
        chk("ready_idle", tx_ready, 1);
        tx_data = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("clk_oe_after_accept", ps2_clk_oe, 1);
        chk("busy_after_accept", {busy, tx_ready}, 2'b10);
        if (mode >= 0) begin
            e.kind = mode;
            e.bits = ref_bits(d);
            sbq.push_back(e);
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("reset_state",
            {ps2_clk_oe, ps2_data_oe, tx_ready, busy, tx_done, tx_error}, 6'b001000);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", {tx_ready, busy}, 2'b10);

        // Set-LEDs command, with an extra request while busy that must be dropped
        start(8'hED, K_DONE, 15, 1'b0);
        repeat (5) @(negedge clk);
        tx_data = 8'h55;
        tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        tx_valid = 1'b0;
        wait_idle();

        start(8'h01, K_DONE, 12, 1'b0);
        wait_idle();

        start(8'($urandom), K_NOACK, 14, 1'b0);
        wait_idle();

        start(8'($urandom), K_TMO, 14, 1'b0);
        wait_idle();

        // Reset while bit_cnt = 4: lines released, no completion pulse
        start(8'h3C, -1, 15, 1'b0);
        n = 0;
        while (dev_falls < 4 && n < INH + TMO) begin
            @(negedge clk);
            n++;
        end
        chk("reached_fall4", dev_falls, 4);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_xfer",
            {ps2_clk_oe, ps2_data_oe, tx_ready, busy, tx_done, tx_error}, 6'b001000);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        start(8'hFF, K_DONE, 15, 1'b0);
        wait_idle();

`ifdef PS2_TX_GLITCH_FILTER_EN
        start(8'hEE, K_DONE, 16, 1'b1);
        wait_idle();
`endif

        for (int i = 0; i < 12; i++) begin
            start(8'($urandom), ($urandom_range(0, 3) == 0) ? K_NOACK : K_DONE,
                  int'($urandom_range(10, 25)), 1'b0);
            wait_idle();
        end

        repeat (20) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

endmodule
